// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_pkg
//  Description : Shared defaults and sequencer state encoding for the
//                register-bank command front-end.
//  Revision    : 1.0  initial release
// ============================================================================
package regbank_pkg;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned AW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with head-of-queue read data and an
//                extra count bit to separate full from empty.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned  PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]  c_depth = (PW+1)'(DEPTH);
    localparam logic [PW:0]  c_one   = (PW+1)'(1);
    localparam logic [PW-1:0] c_step = PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_pop_ok  = pop & ~empty;
    // A simultaneous pop frees the slot, so a push is legal even when full.
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_step;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_step;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regbank_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_cmd_sequencer
//  Description : Queues read/write commands and plays them one at a time
//                onto the register bank, returning read data with backpressure.
//  Revision    : 1.0  initial release
// ============================================================================
module regbank_cmd_sequencer
    import regbank_pkg::*;
#(
    parameter int unsigned DW       = DW_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned FIFO_D   = 4,
    parameter int unsigned READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_wr,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [AW-1:0] rsp_addr,
    output logic [DW-1:0] rsp_data,
    output logic          bank_rd,
    output logic          bank_wr,
    output logic [AW-1:0] bank_addr,
    output logic [DW-1:0] bank_wdata,
    input  logic [DW-1:0] bank_rdata,
    output logic          busy
);

    localparam int unsigned   FW         = DW + AW + 1;
    localparam int unsigned   LW         = $clog2(READ_LAT + 1);
    localparam logic [LW-1:0] c_lat_last = LW'(READ_LAT - 1);
    localparam logic [LW-1:0] c_lat_one  = LW'(1);

    state_t          r_state;
    state_t          w_next_state;
    logic            r_cmd_wr;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [LW-1:0]   r_lat_cnt;
    logic [AW-1:0]   r_rsp_addr;
    logic [DW-1:0]   r_rsp_data;

    logic            w_push;
    logic            w_pop;
    logic            w_capture;
    logic            w_full;
    logic            w_empty;
    logic [FW-1:0]   w_head;
    logic            w_head_wr;
    logic [AW-1:0]   w_head_addr;
    logic [DW-1:0]   w_head_data;

    // Held low through reset so nothing is accepted while rst_n is asserted.
    assign cmd_ready   = rst_n & ~w_full;
    assign w_push      = cmd_valid & cmd_ready;
    assign w_head_wr   = w_head[FW-1];
    assign w_head_addr = w_head[DW +: AW];
    assign w_head_data = w_head[DW-1:0];

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({cmd_wr, cmd_addr, cmd_wdata}),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        bank_rd      = 1'b0;
        bank_wr      = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bank_wr      = r_cmd_wr;
                bank_rd      = ~r_cmd_wr;
                w_next_state = r_cmd_wr ? ST_IDLE : ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (r_lat_cnt == c_lat_last) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cmd_wr   <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lat_cnt  <= '0;
            r_rsp_addr <= '0;
            r_rsp_data <= '0;
        end else begin
            if (w_pop) begin
                r_cmd_wr <= w_head_wr;
                r_addr   <= w_head_addr;
                // Reads leave the bank data bus at its last written value.
                if (w_head_wr) begin
                    r_wdata <= w_head_data;
                end
            end
            if (r_state == ST_ISSUE) begin
                r_lat_cnt <= '0;
            end else if (r_state == ST_WAIT_RD) begin
                r_lat_cnt <= r_lat_cnt + c_lat_one;
            end
            if (w_capture) begin
                r_rsp_addr <= r_addr;
                r_rsp_data <= bank_rdata;
            end
        end
    end

    assign bank_addr  = r_addr;
    assign bank_wdata = r_wdata;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_data   = r_rsp_data;
    assign busy       = ~w_empty | (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_regbank_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_regbank_cmd_sequencer
//  Description : Scoreboard bench for regbank_cmd_sequencer with a simple
//                16x8 bank model attached to the bank port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regbank_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_wr;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       bank_rd, bank_wr;
    logic [3:0] bank_addr;
    logic [7:0] bank_wdata, bank_rdata;
    logic       busy;

    always #5 clk = ~clk;

    regbank_cmd_sequencer #(
        .DW(8), .AW(4), .FIFO_D(4), .READ_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .bank_rd(bank_rd), .bank_wr(bank_wr), .bank_addr(bank_addr),
        .bank_wdata(bank_wdata), .bank_rdata(bank_rdata), .busy(busy)
    );

    // Bank model: registered read, one cycle of latency.
    logic [7:0] bank_mem [16];
    always @(posedge clk) begin
        if (bank_wr) bank_mem[bank_addr] <= bank_wdata;
        if (bank_rd) bank_rdata <= bank_mem[bank_addr];
    end

    typedef struct { logic wr; logic [3:0] addr; logic [7:0] data; } op_t;
    typedef struct { logic [3:0] addr; logic [7:0] data; } rsp_t;

    op_t        exp_ops [$];
    rsp_t       exp_rsp [$];
    logic [7:0] ref_mem [16];
    int         tests = 0;
    int         fails = 0;
    logic       hold_v = 1'b0;
    logic [3:0] hold_a;
    logic [7:0] hold_d;
    logic [7:0] last_rsp = 8'h00;
    logic       rand_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reference model updates at command acceptance, checks at every DUT output event.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_ops.delete();
            exp_rsp.delete();
            ref_mem = bank_mem;
            hold_v  = 1'b0;
        end else begin
            if (bank_rd || bank_wr) begin
                chk("strobe_exclusive", {31'd0, bank_rd & bank_wr}, 32'd0);
                if (exp_ops.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_strobe: got rd=%0b wr=%0b, expected no strobe at %0t",
                             bank_rd, bank_wr, $time);
                end else begin
                    op_t op;
                    op = exp_ops.pop_front();
                    chk("strobe_kind", {31'd0, bank_wr}, {31'd0, op.wr});
                    chk("strobe_addr", {28'd0, bank_addr}, {28'd0, op.addr});
                    if (op.wr) chk("strobe_wdata", {24'd0, bank_wdata}, {24'd0, op.data});
                end
            end
            if (rsp_valid) begin
                chk("strobe_during_resp", {30'd0, bank_rd, bank_wr}, 32'd0);
                if (hold_v) begin
                    chk("hold_addr", {28'd0, rsp_addr}, {28'd0, hold_a});
                    chk("hold_data", {24'd0, rsp_data}, {24'd0, hold_d});
                end
                if (rsp_ready) begin
                    if (exp_rsp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_rsp: got addr=%0h data=%0h, expected none at %0t",
                                 rsp_addr, rsp_data, $time);
                    end else begin
                        rsp_t r;
                        r = exp_rsp.pop_front();
                        chk("rsp_addr", {28'd0, rsp_addr}, {28'd0, r.addr});
                        chk("rsp_data", {24'd0, rsp_data}, {24'd0, r.data});
                    end
                    last_rsp = rsp_data;
                end
            end
            hold_v = rsp_valid && !rsp_ready;
            hold_a = rsp_addr;
            hold_d = rsp_data;
            if (cmd_valid && cmd_ready) begin
                if (cmd_wr) begin
                    ref_mem[cmd_addr] = cmd_wdata;
                    exp_ops.push_back('{1'b1, cmd_addr, cmd_wdata});
                end else begin
                    exp_ops.push_back('{1'b0, cmd_addr, 8'h00});
                    exp_rsp.push_back('{cmd_addr, ref_mem[cmd_addr]});
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic wr, input logic [3:0] addr, input logic [7:0] data);
        int n;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'd1, 32'd0);
        sync();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_rsp.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 32'd1, 32'd0);
        sync();
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 4'h2;
        cmd_wdata = 8'h55;
        rsp_ready = 1'b0;
        rand_done = 1'b0;

        // Reset held for two edges with a command offered.
        sync();
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_strobes", {30'd0, bank_rd, bank_wr}, 32'd0);
        sync();
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_bank_addr", {28'd0, bank_addr}, 32'd0);
        chk("post_rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        sync();

        // Write then read the same location.
        rsp_ready = 1'b1;
        send(1'b1, 4'h8, 8'h18);
        send(1'b0, 4'h8, 8'h00);
        wait_idle();
        chk("wr_rd_data", {24'd0, last_rsp}, 32'h18);

        // Fill the FIFO behind a stalled response, then release.
        rsp_ready = 1'b0;
        send(1'b0, 4'h8, 8'h00);
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        sync();
        for (int i = 0; i < 4; i++) send(1'b1, 4'(i), 8'(8'h30 + i));
        @(negedge clk);
        chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_no_strobe", {30'd0, bank_rd, bank_wr}, 32'd0);
        end
        sync();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        chk("gap_no_strobe", {30'd0, bank_rd, bank_wr}, 32'd0);
        chk("gap_still_full", {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        chk("issue_after_hs", {31'd0, bank_wr}, 32'd1);
        wait_idle();

        // Back-to-back same-address writes then read.
        send(1'b1, 4'h3, 8'hA5);
        send(1'b1, 4'h3, 8'h81);
        send(1'b0, 4'h3, 8'h00);
        wait_idle();
        chk("order_data", {24'd0, last_rsp}, 32'h81);

        // Reset while a read waits on the bank with two commands queued.
        send(1'b0, 4'h7, 8'h00);
        send(1'b1, 4'h9, 8'h11);
        send(1'b1, 4'hA, 8'h22);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        sync();
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst6_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst6_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        sync();

        // Randomised traffic with random response backpressure.
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) sync();
                    send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), 8'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    sync();
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_idle();
        chk("final_rsp_queue", exp_rsp.size(), 32'd0);
        chk("final_op_queue", exp_ops.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
